// File: rtl/aidc_lite_comp_zrle.sv
// aidc_lite_comp_zrle: zero-run-length encoder packing 8x64-bit words into a 32-bit code stream
module aidc_lite_comp_zrle #(
    parameter logic [1:0] ALGO_ID = 2'b01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    input  logic [63:0] data_i,
    output logic        ready_o,
    output logic        valid_o,
    output logic        sop_o,
    output logic        eop_o,
    output logic [31:0] data_o,
    output logic [4:0]  len_o,
    output logic        busy_o
);
    typedef enum logic [1:0] {IDLE, ACCEPT, DRAIN} state_t;
    state_t state, state_n;
    logic [127:0] bits_q, bits_n;
    logic [7:0] fill, fill_n, fill_ap;
    logic [2:0] cnt, k, plen;
    logic [4:0] ocnt;
    logic first_q, accept, pop, eop_n;
    logic [3:0] nz;
    logic [63:0] pl;
    logic [5:0] pbits;
    logic [67:0] code;
    logic [6:0] clen;
    always_comb begin
        nz = {|data_i[63:48], |data_i[47:32], |data_i[31:16], |data_i[15:0]};
        k = 3'($countones(nz));
        pl = '0;
        for (int i = 3; i >= 0; i--)
            if (nz[i]) pl = {pl[47:0], data_i[16*i +: 16]};
        pl = pl << (7'd64 - {k, 4'b0});
        case (nz)
            4'b0000: {plen, pbits} = {3'd6, 6'b000000};
            4'b0001: {plen, pbits} = {3'd6, 6'b000001};
            4'b0010: {plen, pbits} = {3'd5, 6'b000001};
            4'b0100: {plen, pbits} = {3'd5, 6'b000010};
            4'b1000: {plen, pbits} = {3'd5, 6'b000011};
            4'b0011: {plen, pbits} = {3'd4, 6'b000010};
            4'b0101: {plen, pbits} = {3'd4, 6'b000011};
            4'b1001: {plen, pbits} = {3'd4, 6'b000100};
            4'b0110: {plen, pbits} = {3'd4, 6'b000101};
            4'b1010: {plen, pbits} = {3'd4, 6'b000110};
            4'b1100: {plen, pbits} = {3'd4, 6'b000111};
            4'b0111: {plen, pbits} = {3'd4, 6'b001000};
            4'b1011: {plen, pbits} = {3'd4, 6'b001001};
            4'b1101: {plen, pbits} = {3'd4, 6'b001010};
            4'b1110: {plen, pbits} = {3'd4, 6'b001011};
            default: {plen, pbits} = {3'd2, 6'b000011};
        endcase
        // code is MSB-aligned in 68 bits; the first word of a block carries the algorithm prefix
        code = ({pbits, 62'b0} << (3'd6 - plen)) | ({pl, 4'b0} >> plen);
        clen = {4'b0, plen} + {k, 4'b0};
        if (state == IDLE) begin
            code = {ALGO_ID, code[67:2]};
            clen = clen + 7'd2;
        end
    end
    always_comb begin
        accept = valid_i && ready_o;
        pop = fill >= 8'd32 || (state == DRAIN && fill != 8'd0);
        eop_n = state == DRAIN && fill != 8'd0 && fill <= 8'd32;
        fill_ap = !pop ? fill : (fill >= 8'd32 ? fill - 8'd32 : 8'd0);
        bits_n = (pop ? bits_q << 32 : bits_q) | (accept ? {code, 60'b0} >> fill_ap : 128'b0);
        fill_n = fill_ap + (accept ? {1'b0, clen} : 8'd0);
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_n;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? ACCEPT : IDLE;
            ACCEPT:  state_n = (accept && cnt == 3'd7) ? DRAIN : ACCEPT;
            default: state_n = eop_n ? IDLE : DRAIN;
        endcase
    end
    always_comb begin
        ready_o = rst_n && (state == IDLE || (state == ACCEPT && fill <= 8'd60));
        busy_o = state != IDLE;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            bits_q <= '0;
            fill <= '0;
            cnt <= '0;
            ocnt <= '0;
            first_q <= 1'b0;
            valid_o <= 1'b0;
            sop_o <= 1'b0;
            eop_o <= 1'b0;
            data_o <= '0;
            len_o <= '0;
        end else begin
            bits_q <= bits_n;
            fill <= fill_n;
            if (accept) cnt <= (state == IDLE) ? 3'd1 : cnt + 3'd1;
            if (accept && state == IDLE) first_q <= 1'b1;
            else if (pop) first_q <= 1'b0;
            valid_o <= pop;
            sop_o <= pop && first_q;
            eop_o <= eop_n;
            data_o <= pop ? bits_q[127:96] : 32'b0;
            len_o <= eop_n ? ocnt + 5'd1 : 5'd0;
            ocnt <= eop_n ? 5'd0 : (pop ? ocnt + 5'd1 : ocnt);
        end
endmodule

// File: tb/tb_aidc_lite_comp_zrle.sv
// tb_aidc_lite_comp_zrle: random and directed blocks checked against a bit-queue encoder and a decoder model
module tb_aidc_lite_comp_zrle;
    logic clk = 0, rst_n = 0, valid_i = 0;
    logic [63:0] data_i = '0;
    logic ready_o, valid_o, sop_o, eop_o, busy_o;
    logic [31:0] data_o;
    logic [4:0] len_o;

    aidc_lite_comp_zrle #(.ALGO_ID(2'b01)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .data_i(data_i), .ready_o(ready_o),
        .valid_o(valid_o), .sop_o(sop_o), .eop_o(eop_o), .data_o(data_o), .len_o(len_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // prefix table indexed by lane pattern {w3,w2,w1,w0}, 1 = non-zero lane
    localparam logic [5:0] PV [16] = '{6'b000000, 6'b000001, 6'b00001, 6'b0010, 6'b00010, 6'b0011, 6'b0101, 6'b1000,
                                      6'b00011, 6'b0100, 6'b0110, 6'b1001, 6'b0111, 6'b1010, 6'b1011, 6'b11};
    localparam int PL [16] = '{6, 6, 5, 4, 5, 4, 4, 4, 5, 4, 4, 4, 4, 4, 4, 2};

    int checks = 0, errors = 0;
    bit mq[$];
    logic [63:0] stim_q[$], in_blk[$];
    logic [31:0] rx[$], last_blk[$];
    int acc_cnt = 0, out_cnt = 0, blocks_done = 0, gap = 0, nready_cnt = 0, rem;
    bit run = 0, eop_e;
    logic [31:0] w;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [63:0] d);
        int p;
        p = 0;
        for (int i = 0; i < 4; i++) if (d[16*i +: 16] != 16'h0) p |= 1 << i;
        if (acc_cnt == 0) begin mq.push_back(1'b0); mq.push_back(1'b1); end
        for (int b = PL[p] - 1; b >= 0; b--) mq.push_back(PV[p][b]);
        for (int i = 3; i >= 0; i--)
            if (p[i]) for (int b = 15; b >= 0; b--) mq.push_back(d[16*i + b]);
    endtask

    task automatic decode_block();
        bit b[$];
        int idx, found;
        logic [63:0] dw;
        logic [1:0] algo;
        foreach (rx[n]) for (int i = 31; i >= 0; i--) b.push_back(rx[n][i]);
        algo = {b[0], b[1]};
        chk("algo_prefix", algo, 2'b01);
        idx = 2;
        for (int n = 0; n < 8; n++) begin
            found = -1;
            for (int p = 0; p < 16; p++) begin
                bit m = 1;
                for (int j = 0; j < PL[p]; j++)
                    if (idx + j >= b.size() || b[idx + j] != PV[p][PL[p] - 1 - j]) m = 0;
                if (m) found = p;
            end
            if (found < 0) begin
                chk("decode_prefix", 64'd0, 64'd1);
                return;
            end
            idx += PL[found];
            dw = '0;
            for (int i = 3; i >= 0; i--)
                if (found[i]) for (int j = 15; j >= 0; j--) begin
                    dw[16*i + j] = (idx < b.size()) ? b[idx] : 1'b0;
                    idx++;
                end
            chk("roundtrip", dw, in_blk[n]);
        end
        chk("pad_lt_32", 64'(b.size() - idx < 32), 64'd1);
    endtask

    always @(negedge clk) if (run) begin
        if (valid_o) begin
            rem = mq.size();
            w = '0;
            for (int i = 0; i < 32; i++) if (mq.size() != 0) w[31 - i] = mq.pop_front();
            eop_e = acc_cnt == 8 && rem <= 32;
            chk("data_o", data_o, w);
            chk("sop_o", sop_o, out_cnt == 0);
            chk("eop_o", eop_o, eop_e);
            out_cnt++;
            chk("len_o", len_o, eop_e ? out_cnt : 0);
            rx.push_back(data_o);
            if (eop_e) begin
                decode_block();
                last_blk = rx;
                rx.delete();
                in_blk.delete();
                mq.delete();
                acc_cnt = 0;
                out_cnt = 0;
                blocks_done++;
            end
        end else
            chk("idle_outputs", {sop_o, eop_o, data_o, len_o}, '0);
        chk("busy_o", busy_o, acc_cnt != 0);
        if (acc_cnt == 8) chk("ready_drain", ready_o, 0);
        else if (acc_cnt == 0) chk("ready_idle", ready_o, 1);
        else chk("ready_fill", ready_o, mq.size() <= 60);
        if (stim_q.size() != 0 && $urandom_range(99) >= gap) begin
            valid_i = 1;
            data_i = stim_q[0];
            if (ready_o) begin
                void'(stim_q.pop_front());
                push_word(data_i);
                in_blk.push_back(data_i);
                acc_cnt++;
            end else nready_cnt++;
        end else begin
            valid_i = 0;
            data_i = {$urandom, $urandom};
        end
    end

    task automatic wait_blocks(input int target);
        int c;
        c = 0;
        while (blocks_done < target && c < 3000) begin @(posedge clk); c++; end
        if (blocks_done < target) begin
            checks++; errors++;
            $display("FAIL block_timeout actual=%0d expected=%0d", blocks_done, target);
        end
    endtask

    function automatic logic [63:0] rand_word(input int p);
        logic [63:0] r;
        for (int i = 0; i < 4; i++) r[16*i +: 16] = p[i] ? 16'($urandom_range(65535, 1)) : 16'h0;
        return r;
    endfunction

    initial begin
        #1;
        chk("reset_outputs", {valid_o, sop_o, eop_o, data_o, len_o, busy_o}, '0);
        @(negedge clk); @(negedge clk); rst_n = 1;
        @(posedge clk); run = 1;
        chk("ready_after_reset", ready_o, 1);
        repeat (8) stim_q.push_back(64'h0);
        wait_blocks(1);
        chk("zero_len", last_blk.size(), 2);
        chk("zero_w0", last_blk[0], 32'h40000000);
        chk("zero_w1", last_blk[1], 32'h00000000);
        stim_q.push_back(64'h1234);
        repeat (7) stim_q.push_back(64'h0);
        wait_blocks(2);
        chk("one_len", last_blk.size(), 3);
        chk("one_w0", last_blk[0], 32'h41123400);
        chk("one_w2", last_blk[2], 32'h0);
        nready_cnt = 0;
        repeat (8) stim_q.push_back({64{1'b1}});
        wait_blocks(3);
        chk("ones_len", last_blk.size(), 17);
        chk("ones_w0", last_blk[0], 32'h7FFFFFFF);
        chk("ones_last", last_blk[16], 32'hFFFFC000);
        chk("ones_backpressure", nready_cnt > 0, 1);
        for (int p = 0; p < 16; p++) stim_q.push_back(rand_word(p));
        wait_blocks(5);
        gap = 40;
        repeat (48) stim_q.push_back(rand_word($urandom_range(15)));
        wait_blocks(11);
        gap = 0;
        repeat (8) stim_q.push_back({64{1'b1}});
        for (int c = 0; c < 200 && acc_cnt != 8; c++) @(posedge clk);
        chk("reached_drain", acc_cnt, 8);
        @(posedge clk); #2;
        run = 0; rst_n = 0; valid_i = 0;
        #1;
        chk("reset_in_drain", {valid_o, sop_o, eop_o, data_o, len_o, busy_o}, '0);
        mq.delete(); stim_q.delete(); in_blk.delete(); rx.delete();
        acc_cnt = 0; out_cnt = 0;
        @(negedge clk); rst_n = 1;
        @(posedge clk); run = 1;
        stim_q.push_back(64'h1234);
        repeat (7) stim_q.push_back(64'h0);
        wait_blocks(12);
        chk("post_reset_w0", last_blk[0], 32'h41123400);
        chk("post_reset_len", last_blk.size(), 3);
        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/aidc_lite_comp_zrle.md
# aidc_lite_comp_zrle

Zero-run-length (ZRLE) compressor for AIDC-Lite. It takes one 512-bit block as eight 64-bit words and encodes each word by its zero/non-zero 16-bit lane pattern. It packs the codes MSB-first behind a 2-bit algorithm prefix into a stream of 32-bit words. The stream is bit-exact with the input format of the ZRLE decompressor, so this block is the write-side partner of that decompressor in the compression path.

## Interface
- `ALGO_ID`, default `2'b01`: 2-bit prefix placed in bits [31:30] of the first output word.
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `valid_i`, in, 1: input word valid.
- `data_i`, in, 64: input word; lanes w3=[63:48], w2=[47:32], w1=[31:16], w0=[15:0].
- `ready_o`, out, 1: block accepts `data_i` this cycle; a transfer occurs when `valid_i && ready_o`.
- `valid_o`, out, 1: output word valid; there is no backpressure.
- `sop_o`, out, 1: first word of the block.
- `eop_o`, out, 1: last word of the block.
- `data_o`, out, 32: packed code bits, MSB first; forced to 0 when `valid_o` is 0.
- `len_o`, out, 5: number of words in the block (1..17); valid with `eop_o`, 0 otherwise.
- `busy_o`, out, 1: block in progress (from first accept until the `eop_o` cycle).

## Operation
- A lane is Z if it equals 16'h0, otherwise N. Codes (prefix bits, then payload lanes in high-to-low order):
  - ZZZZ: `000000` (6 bits).
  - ZZZN: `000001`+w0 (22 bits).
  - ZZNZ, ZNZZ, NZZZ: `00001`+w1, `00010`+w2, `00011`+w3 (21 bits).
  - ZZNN, ZNZN, NZZN, ZNNZ, NZNZ, NNZZ: `0010`, `0011`, `0100`, `0101`, `0110`, `0111`, plus two lanes (36 bits).
  - ZNNN, NZNN, NNZN, NNNZ: `1000`, `1001`, `1010`, `1011`, plus three lanes (52 bits).
  - NNNN: `11`+w3w2w1w0 (66 bits).
- Bit buffer:
  - 128-bit, MSB-aligned; fill count is 8 bits (0..128).
  - An accepted word's code is appended at bit offset `fill`.
  - The first word of a block is prefixed by `ALGO_ID`, giving at most 68 bits.
- Output pop:
  - If `fill >= 32`, the top 32 bits go to the output register, the buffer shifts left 32, and fill decreases by 32.
  - In DRAIN with `0 < fill < 32`, the remainder is emitted zero-padded, with `eop_o`=1, and fill becomes 0.
  - Pop and append in the same cycle are both applied: `fill_n = fill - pop + append`.
- State machine:
  - IDLE: `ready_o`=1. An accept moves to ACCEPT with word count 1 and sets `busy_o`.
  - ACCEPT: `ready_o = (fill <= 60)`, using registered fill. The 8th accept (count 7→0 wrap) moves to DRAIN.
  - DRAIN: `ready_o`=0. Pop words until fill reaches 0. The last pop carries `eop_o`, and the state returns to IDLE.
  - If fill is exactly a multiple of 32, the last full pop carries `eop_o`.
- `sop_o` is set on the first emitted word of a block.
- Word counter: 5 bits. `len_o` equals the count of words emitted in the block, including the eop word.
- Total bits per block are 2 + Σcode; the maximum is 530, i.e. 17 words with 18 payload bits in the last word.

## Timing
- Reset (async, `rst_n`=0): state IDLE, fill 0, buffer 0.
  - Outputs: `valid_o`=0, `sop_o`=0, `eop_o`=0, `data_o`=0, `len_o`=0, `busy_o`=0, `ready_o`=1 after release.
- Reset mid-block discards all buffered bits; no `eop_o` is produced for that block.
- Latency: a word accepted at edge k updates fill at k. The resulting output word is registered at edge k+1, giving 2 cycles input-to-output.
- A block's first word cannot be accepted until the previous block's `eop_o` cycle; IDLE is entered on that edge.
- `ready_o` never asserts in DRAIN, even when fill is 0.
- Throughput: at most 32 output bits per cycle. `ready_o` drops whenever `fill > 60`.

## Test plan
- Eight all-zero words, `ALGO_ID`=01 → 2 words: 0x40000000 with `sop_o`, then 0x00000000 with `eop_o` and `len_o`=2.
- Word0 = 0x0000_0000_0000_1234, words 1–7 zero → 0x41123400, 0x00000000, 0x00000000 (eop), `len_o`=3.
- Eight words of 0xFFFF_FFFF_FFFF_FFFF → 17 words:
  - word0 = 0x7FFFFFFF (prefix 01, code 11, then ones);
  - last word = 0xFFFFC000, with `eop_o` and `len_o`=17;
  - `ready_o` must deassert while `valid_i` is held high.
- All 16 lane patterns, one per word over two blocks → the decompressor model reproduces every input exactly, and bit counts match the table.
- `valid_i` gaps and back-to-back blocks → no word is lost, `sop_o`/`eop_o` pair up once per block, and `data_o`=0 whenever `valid_o`=0.
- Assert `rst_n` during DRAIN → all outputs are 0 in the same cycle, and the next block encodes correctly from IDLE.
